pipeline_stall_ctrl: RTL and testbench
======================================

// Module: pipeline_stall_ctrl
// PURPOSE
//  Hazard/sequencing controller for the 5-stage RV32 pipeline. Drives stall enables and flushes for
//  the F/D/E/M/W pipeline registers, plus operand-forwarding selects for the EX stage. Owns the
//  req/ack handshake to a variable-latency data memory, freezing the pipe until the MEM-stage access completes.
//  Sits beside the datapath; purely a control consumer of stage fields (Rd*, Rs*, RegWrite*, ResultSrc*, MemWrite*).
// PARAMETERS
//  TIMEOUT_CYCLES  16  max WAIT cycles before access is abandoned (>=1)
//  CNT_W           32  perf counter width (PIPE_PERF_CNT_EN only)
// PORTS
//  clk           in   1   clock
//  reset         in   1   asynchronous, active-high
//  Rs1D,Rs2D     in   5   source regs in Decode
//  Rs1E,Rs2E,RdE in   5   source/dest regs in Execute
//  ResultSrcE    in   2   2'b01 = load in Execute
//  PCSrcE        in   1   taken branch/jump resolved in Execute
//  RdM           in   5   dest reg in Memory
//  RegWriteM     in   1   Memory-stage writes RF
//  MemWriteM     in   1   store in Memory
//  ResultSrcM    in   2   2'b01 = load in Memory
//  RdW           in   5   dest reg in Writeback
//  RegWriteW     in   1   Writeback-stage writes RF
//  dmem_ack      in   1   data memory access complete (same-cycle with req allowed)
//  dmem_req      out  1   data memory access request
//  StallF,StallD,StallE,StallM  out 1 hold corresponding pipeline register (en = ~Stall)
//  FlushD,FlushE,FlushW         out 1 load bubble (clear) into D/E/W register
//  ForwardAE,ForwardBE          out 2 00 RF, 01 Writeback result, 10 Memory ALUResult
//  dmem_timeout  out  1   sticky: an access exceeded TIMEOUT_CYCLES
// BEHAVIOUR
//  - Reset: FSM=IDLE, timeout counter=0, dmem_timeout=0; while reset high all Stall*/Flush*/dmem_req=0, Forward*=00.
//  - memop = MemWriteM | (ResultSrcM==2'b01).
//  - FSM IDLE: dmem_req=memop. memop & dmem_ack -> stay IDLE, no stall (zero-wait).
//    memop & ~dmem_ack -> go WAIT; this cycle: StallF/D/E/M=1, FlushW=1.
//  - FSM WAIT: dmem_req=1, StallF/D/E/M=1, FlushW=1, count++. dmem_ack -> IDLE, stalls released this cycle
//    (instruction advances at this edge). count==TIMEOUT_CYCLES-1 w/o ack -> set dmem_timeout, IDLE, release as with ack.
//  - Timeout counter cleared on every IDLE entry. Exactly one req/ack transaction per instruction in M.
//  - Load-use: lwStall = (ResultSrcE==01) & RdE!=0 & (Rs1D==RdE | Rs2D==RdE) -> StallF, StallD, FlushE.
//  - Branch: PCSrcE -> FlushD, FlushE. PCSrcE wins over lwStall for StallF/StallD (no stall when flushing).
//  - Memory wait dominates: while stalled on dmem, FlushD/FlushE/lwStall effects suppressed (held stage re-evaluates after).
//  - Forward A: RegWriteM & RdM!=0 & RdM==Rs1E -> 10; else RegWriteW & RdW!=0 & RdW==Rs1E -> 01; else 00. B same with Rs2E.
//    M beats W when both match. x0 never forwarded.
//  - Reset mid-WAIT: transaction abandoned, dmem_req drops asynchronously, FSM IDLE.
//  - Stall/flush/forward outputs combinational from inputs+state; dmem_timeout registered.
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined: adds outputs stall_cycles[CNT_W] (cycles with StallF=1), flush_events[CNT_W]
//  (cycles with FlushD|FlushE), both reset to 0, saturate at all-ones. Undefined: ports and logic absent.
// STRUCTURE
//  pipe_ctrl_pkg: typedef enum logic {MS_IDLE, MS_WAIT} mem_state_t; localparams FWD_RF=2'b00,
//   FWD_WB=2'b01, FWD_MEM=2'b10, RESULT_SRC_LOAD=2'b01.
//  Sub-module pipe_forward_unit (combinational, one instance per operand A/B).
// TESTING
//  1 lw x5 in E, Rs1D=5 -> StallF=StallD=FlushE=1 one cycle; RdE=0 with Rs1D=0 -> no stall.
//  2 RegWriteM=1,RdM=3; RegWriteW=1,RdW=3; Rs1E=3 -> ForwardAE=10; RdM=0 -> ForwardAE=01.
//  3 Store in M, dmem_ack after 3 cycles -> dmem_req 4 cycles, Stall*/FlushW=1 for 3, released on ack cycle.
//  4 Load in M, ack never, TIMEOUT_CYCLES=16 -> stall 16 cycles, dmem_timeout=1 sticky, FSM IDLE.
//  5 PCSrcE=1 with lwStall=1 -> FlushD=FlushE=1, StallF=StallD=0; same during dmem WAIT -> flushes 0.
//  6 Assert reset in WAIT cycle 2 -> dmem_req, stalls 0 immediately; after release zero-wait access has no stall.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

   typedef enum logic {
      MS_IDLE = 1'b0,
      MS_WAIT = 1'b1
   } mem_state_t;

   localparam logic [1:0] FWD_RF          = 2'b00;
   localparam logic [1:0] FWD_WB          = 2'b01;
   localparam logic [1:0] FWD_MEM         = 2'b10;
   localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

   function automatic logic is_load(input logic [1:0] result_src);
      return result_src == RESULT_SRC_LOAD;
   endfunction

endpackage

// File: rtl/pipe_forward_unit.sv
// EX-stage operand forwarding select for one source operand.
// Memory-stage result has priority over Writeback; x0 is never forwarded.
module pipe_forward_unit
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] rs_e_i,
   input  logic [4:0] rd_m_i,
   input  logic       reg_write_m_i,
   input  logic [4:0] rd_w_i,
   input  logic       reg_write_w_i,
   output logic [1:0] fwd_o
);

   // Youngest producer wins: M before W, RF otherwise.
   always_comb begin
      fwd_o = FWD_RF;
      if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_e_i))
         fwd_o = FWD_MEM;
      else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_e_i))
         fwd_o = FWD_WB;
   end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32 pipeline.
// Produces stall/flush enables, EX forwarding selects and the data-memory
// req/ack handshake (freezes the pipe while an M-stage access is pending).
// Optional build macro PIPE_PERF_CNT_EN adds stall_cycles / flush_events
// saturating performance counters.
module pipeline_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned CNT_W          = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic [1:0]       ResultSrcE,
   input  logic             PCSrcE,
   input  logic [4:0]       RdM,
   input  logic             RegWriteM,
   input  logic             MemWriteM,
   input  logic [1:0]       ResultSrcM,
   input  logic [4:0]       RdW,
   input  logic             RegWriteW,
   input  logic             dmem_ack,
   output logic             dmem_req,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             dmem_timeout
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
`endif
);

   // Wait counter only needs to reach TIMEOUT_CYCLES-1.
   localparam int unsigned   TCW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TCW-1:0] T_LAST = TCW'(TIMEOUT_CYCLES - 1);

   if (TIMEOUT_CYCLES < 1 || CNT_W < 1) begin : g_param_chk
      $error("pipeline_stall_ctrl: TIMEOUT_CYCLES and CNT_W must be >= 1");
   end

   mem_state_t     state_q, state_d;
   logic [TCW-1:0] cnt_q, cnt_d;
   logic           timeout_q, timeout_d;
   logic           memop, mem_stall, lw_stall;

   logic [1:0][4:0] rs_e;
   logic [1:0][1:0] fwd_sel;

   assign memop    = MemWriteM | is_load(ResultSrcM);
   assign lw_stall = is_load(ResultSrcE) && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));
   assign rs_e     = {Rs2E, Rs1E};

   // One forwarding unit per EX source operand (0 = A/Rs1E, 1 = B/Rs2E).
   for (genvar g = 0; g < 2; g++) begin : g_fwd
      pipe_forward_unit u_fwd (
         .rs_e_i        (rs_e[g]),
         .rd_m_i        (RdM),
         .reg_write_m_i (RegWriteM),
         .rd_w_i        (RdW),
         .reg_write_w_i (RegWriteW),
         .fwd_o         (fwd_sel[g])
      );
   end

   // Memory FSM state, wait counter and sticky timeout flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= MS_IDLE;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   // Next state and pipe freeze: the ack (or timeout) cycle releases the
   // stall so the M instruction advances on that same edge.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      mem_stall = 1'b0;
      case (state_q)
         MS_IDLE: begin
            cnt_d = '0;
            if (memop && !dmem_ack) begin
               state_d   = MS_WAIT;
               mem_stall = 1'b1;
            end
         end
         MS_WAIT: begin
            if (dmem_ack) begin
               state_d = MS_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == T_LAST) begin
               state_d   = MS_IDLE;
               cnt_d     = '0;
               timeout_d = 1'b1;
            end else begin
               mem_stall = 1'b1;
               cnt_d     = cnt_q + TCW'(1);
            end
         end
         default: begin
            state_d = MS_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Stall/flush/forward decode; a pending memory access masks the
   // load-use and branch effects, and reset forces everything quiet.
   always_comb begin
      dmem_req  = 1'b0;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushW    = 1'b0;
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      if (!reset) begin
         dmem_req  = (state_q == MS_WAIT) | memop;
         StallF    = mem_stall | (lw_stall & ~PCSrcE);
         StallD    = mem_stall | (lw_stall & ~PCSrcE);
         StallE    = mem_stall;
         StallM    = mem_stall;
         FlushD    = ~mem_stall & PCSrcE;
         FlushE    = ~mem_stall & (PCSrcE | lw_stall);
         FlushW    = mem_stall;
         ForwardAE = fwd_sel[0];
         ForwardBE = fwd_sel[1];
      end
   end

   assign dmem_timeout = timeout_q;

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   // Saturating counts of fetch-stall cycles and D/E flush cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (StallF && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if ((FlushD || FlushE) && (flush_cnt_q != '1))
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign stall_cycles = stall_cnt_q;
   assign flush_events = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios with
// literal expectations plus randomized traffic compared every cycle
// against a behavioural model of the hazard rules and memory handshake.
module tb_pipeline_stall_ctrl;

   localparam int TMO = 16;
   localparam int CW  = 32;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic [1:0] ResultSrcE, ResultSrcM;
   logic       PCSrcE, RegWriteM, MemWriteM, RegWriteW, dmem_ack;
   logic       dmem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, dmem_timeout;
   logic [1:0] ForwardAE, ForwardBE;
`ifdef PIPE_PERF_CNT_EN
   logic [CW-1:0] stall_cycles, flush_events;
`endif

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   pipeline_stall_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
      .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
      .RdW(RdW), .RegWriteW(RegWriteW), .dmem_ack(dmem_ack),
      .dmem_req(dmem_req), .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .dmem_timeout(dmem_timeout)
`ifdef PIPE_PERF_CNT_EN
      , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // age = cycles the current M access has already spent requesting without ack.
   int         age = 0;
   logic       tmo_m = 1'b0;
   logic       memop_m, active_m, memstall_m, lw_m;
   logic [12:0] exp_o, act_o;
`ifdef PIPE_PERF_CNT_EN
   logic [CW-1:0] sc_m = '0, fe_m = '0;
`endif

   function automatic logic [1:0] fwd_m(input logic [4:0] rs, input logic wm, input logic [4:0] rdm,
                                        input logic ww, input logic [4:0] rdw);
      if (wm && rdm != 0 && rdm == rs) return 2'b10;
      if (ww && rdw != 0 && rdw == rs) return 2'b01;
      return 2'b00;
   endfunction

   assign memop_m    = MemWriteM | (ResultSrcM == 2'b01);
   assign active_m   = (age > 0) | memop_m;
   assign memstall_m = active_m & ~dmem_ack & (age < TMO);
   assign lw_m       = (ResultSrcE == 2'b01) && (RdE != 0) && (Rs1D == RdE || Rs2D == RdE);
   assign act_o = {dmem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                   ForwardAE, ForwardBE, dmem_timeout};

   always_comb begin
      exp_o = '0;
      if (!reset) begin
         exp_o[12]  = active_m;
         exp_o[11]  = memstall_m | (lw_m & ~PCSrcE);
         exp_o[10]  = memstall_m | (lw_m & ~PCSrcE);
         exp_o[9]   = memstall_m;
         exp_o[8]   = memstall_m;
         exp_o[7]   = ~memstall_m & PCSrcE;
         exp_o[6]   = ~memstall_m & (PCSrcE | lw_m);
         exp_o[5]   = memstall_m;
         exp_o[4:3] = fwd_m(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
         exp_o[2:1] = fwd_m(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
      end
      exp_o[0] = tmo_m;
   end

   // Model state advance: access ends on ack or after TMO unacknowledged cycles.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         age   <= 0;
         tmo_m <= 1'b0;
`ifdef PIPE_PERF_CNT_EN
         sc_m  <= '0;
         fe_m  <= '0;
`endif
      end else begin
         if (active_m && !dmem_ack && age < TMO) age <= age + 1;
         else age <= 0;
         if (active_m && !dmem_ack && age == TMO) tmo_m <= 1'b1;
`ifdef PIPE_PERF_CNT_EN
         if (exp_o[11] && sc_m != '1) sc_m <= sc_m + 1;
         if ((exp_o[7] || exp_o[6]) && fe_m != '1) fe_m <= fe_m + 1;
`endif
      end
   end

   // Per-cycle compare, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         checks++;
         if (act_o !== exp_o) begin
            errors++;
            $display("FAIL outputs t=%0t got=%b expected=%b (req,SF,SD,SE,SM,FD,FE,FW,FA,FB,tmo)",
                     $time, act_o, exp_o);
         end
`ifdef PIPE_PERF_CNT_EN
         checks++;
         if (stall_cycles !== sc_m || flush_events !== fe_m) begin
            errors++;
            $display("FAIL perf t=%0t got=%0d/%0d expected=%0d/%0d", $time,
                     stall_cycles, flush_events, sc_m, fe_m);
         end
`endif
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic clr();
      Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
      ResultSrcE = 0; ResultSrcM = 0; PCSrcE = 0; RegWriteM = 0; MemWriteM = 0;
      RegWriteW = 0; dmem_ack = 0;
   endtask

   task automatic nxt();
      @(posedge clk); #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int reqs, stalls;
      clr();
      MemWriteM = 1'b1;
      nxt();
      chk_en = 1'b1;
      // Reset: everything quiet even with a store presented.
      smp();
      chk("rst_req", 16'(dmem_req), 16'd0);
      chk("rst_stall", 16'({StallF, StallD, StallE, StallM, FlushW}), 16'd0);
      chk("rst_tmo", 16'(dmem_timeout), 16'd0);
      nxt(); reset = 1'b0; clr();

      // Load-use hazard and x0 exemption.
      ResultSrcE = 2'b01; RdE = 5; Rs1D = 5;
      smp(); chk("lw_stall", 16'({StallF, StallD, FlushE, StallE}), 16'b1110);
      nxt(); clr(); ResultSrcE = 2'b01; RdE = 0; Rs1D = 0;
      smp(); chk("lw_x0", 16'({StallF, StallD, FlushE}), 16'd0);

      // Forwarding priority M over W, and W when RdM is x0.
      nxt(); clr(); RegWriteM = 1; RdM = 3; RegWriteW = 1; RdW = 3; Rs1E = 3; Rs2E = 3;
      smp(); chk("fwd_mem", 16'(ForwardAE), 16'h2);
      nxt(); RdM = 0;
      smp(); chk("fwd_wb_a", 16'(ForwardAE), 16'h1); chk("fwd_wb_b", 16'(ForwardBE), 16'h1);

      // Store acked on its 4th request cycle.
      nxt(); clr(); MemWriteM = 1; reqs = 0; stalls = 0;
      for (int i = 0; i < 4; i++) begin
         dmem_ack = (i == 3);
         smp();
         reqs += int'(dmem_req);
         stalls += int'(StallF & StallD & StallE & StallM & FlushW);
         if (i == 3) chk("st_release", 16'(StallF), 16'd0);
         nxt();
      end
      clr();
      chk("st_req_cycles", 16'(reqs), 16'd4);
      chk("st_stall_cycles", 16'(stalls), 16'd3);

      // Load never acked: stall TMO cycles, then abandon and flag timeout.
      ResultSrcM = 2'b01; stalls = 0;
      for (int i = 0; i <= TMO; i++) begin
         smp();
         stalls += int'(StallF);
         if (i == TMO) chk("tmo_release", 16'({dmem_req, StallF}), 16'b10);
         nxt();
      end
      clr();
      chk("tmo_stall_cycles", 16'(stalls), 16'(TMO));
      smp(); chk("tmo_flag", 16'(dmem_timeout), 16'd1);
      nxt(); nxt();
      smp(); chk("tmo_sticky", 16'({dmem_timeout, dmem_req, StallF}), 16'b100);

      // Branch beats load-use; both suppressed during memory wait.
      nxt(); PCSrcE = 1; ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
      smp(); chk("br_over_lw", 16'({FlushD, FlushE, StallF, StallD}), 16'b1100);
      nxt(); MemWriteM = 1;
      smp(); chk("br_in_wait", 16'({FlushD, FlushE, StallF}), 16'b001);
      nxt(); dmem_ack = 1;
      smp(); chk("br_after_ack", 16'({FlushD, FlushE, StallF}), 16'b110);

      // Reset during WAIT cycle 2 drops req/stalls immediately.
      nxt(); clr(); MemWriteM = 1;
      smp(); nxt();
      smp(); nxt();
      smp(); #2 reset = 1'b1; #1;
      chk("rst_wait_req", 16'(dmem_req), 16'd0);
      chk("rst_wait_stall", 16'({StallF, StallD, StallE, StallM, FlushW}), 16'd0);
      nxt(); reset = 1'b0; dmem_ack = 1;
      smp();
      chk("zw_req", 16'(dmem_req), 16'd1);
      chk("zw_stall", 16'({StallF, StallM, dmem_timeout}), 16'd0);
      nxt(); clr();

      // Randomized traffic with periodic ack droughts and async resets.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
         Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
         RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
         RdW  = 5'($urandom_range(0, 3));
         ResultSrcE = 2'($urandom_range(0, 3));
         ResultSrcM = 2'($urandom_range(0, 3));
         PCSrcE     = ($urandom_range(0, 3) == 0);
         RegWriteM  = 1'($urandom_range(0, 1));
         RegWriteW  = 1'($urandom_range(0, 1));
         MemWriteM  = ($urandom_range(0, 5) == 0);
         dmem_ack   = ((cyc % 500) < 40) ? 1'b0 : ($urandom_range(0, 2) == 0);
         if ((cyc % 700) == 350) begin
            smp(); #2 reset = 1'b1;
            nxt(); reset = 1'b0;
         end else begin
            nxt();
         end
      end

      smp();
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
